mem_dreq: RTL and testbench
===========================

Name: mem_dreq

Overview:
- Memory-stage data-access initiator on the SRAM-like data port. Sits between the EXE/MEM pipeline register outputs and the data bus bridge.
- Turns the registered memory-stage load/store fields into one outstanding bus transaction at a time.
- Raises a stall request while the transaction is in flight, then returns size/sign-extended load data to the MEM/WB path.
- Detects address-alignment exceptions and abandons or drains transactions on flush.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus data width

Ports:
cpu_clk_50M  in  1  system clock
cpu_rst_n  in  1  reset: synchronous, active-low, sampled on rising edge of cpu_clk_50M
mem_aluop  in  ALUOP_BUS  memory-stage operation code
mem_wd  in  32  effective address (computed in EXE)
mem_din  in  32  store data
mem_exccode  in  EXC_CODE_BUS  upstream exception code; EXC_NONE = clean
flush  in  1  pipeline flush (exception/eret)
stall_mem  in  1  stall[4]; STOP = MEM/WB held by another stage
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  bus address, low bits preserved
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data / write ack valid
data_rdata  in  32  read data
stallreq_mem  out  1  memory-stage stall request
mem_ld_data  out  32  extended load result
mem_ld_valid  out  1  mem_ld_data valid for the current instruction
mem_adel  out  1  load address error
mem_ades  out  1  store address error

Behaviour:
- Memory operations: LB, LBU, LH, LHU, LW, SB, SH, SW. Every other aluop is a non-memory op.
- Misalignment (combinational):
  - half access with addr[0]≠0, or word access with addr[1:0]≠0.
  - mem_adel = misaligned load; mem_ades = misaligned store.
- Issue condition, op_go = memory op AND mem_exccode==EXC_NONE AND not misaligned AND not flush.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. Reset → IDLE.
- IDLE:
  - op_go → REQ.
  - On that edge, latch data_wr, data_size, data_addr=mem_wd, data_wdata, and addr[1:0] plus load type for extension.
- REQ:
  - data_req=1; address/data fields are stable until acceptance.
  - addr_ok → WAIT. If addr_ok and flush occur together → DRAIN.
  - flush without addr_ok → IDLE (request withdrawn).
- WAIT:
  - data_ok → DONE; latch the extended load result (loads only).
  - flush → DRAIN. If flush and data_ok occur together → IDLE with result discarded.
- DONE:
  - mem_ld_valid=1 for loads.
  - stall_mem==NOSTOP or flush → IDLE; otherwise hold, with no reissue.
- DRAIN: data_ok → IDLE; result discarded, never valid.
- stallreq_mem = (IDLE & op_go) | REQ | WAIT | (DRAIN & memory op present & not flush). Deasserted in DONE.
- Latency, zero-wait slave: issue edge, REQ+addr_ok, data_ok next cycle, DONE. Four cycles in total; stall spans three cycles.
- The slave never asserts data_ok in the same cycle as addr_ok. data_ok outside WAIT/DRAIN is ignored.
- Store lanes: SB replicates {4{din[7:0]}}; SH replicates {2{din[15:0]}}; SW passes din.
- Load extension: byte selected by addr[1:0], half by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Reset: data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, mem_ld_data=0, mem_ld_valid=0, stallreq_mem=0. Reset mid-transaction abandons it (bus bridge is reset together).

Decomposition:
- Shared defines: aluop codes for the memory ops, EXC_NONE, STOP/NOSTOP, ALUOP_BUS, EXC_CODE_BUS, and size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- One natural combinational sub-module: mem_ld_ext (load type + offset + rdata → extended word).

Test Plan:
- LW at 0x8000_0010, zero-wait slave returning 0x1234_5678 → req one cycle, stall three cycles, mem_ld_data=0x1234_5678 in DONE.
- LB at offset 3, rdata 0x80FF_FFFF → mem_ld_data=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH din 0x0000_ABCD at addr 0x...2 → data_size=1, data_wdata=0xABCD_ABCD, data_wr=1, no mem_ld_valid.
- LW at 0x...2 → mem_adel=1, data_req never asserted, stallreq_mem=0.
- flush in WAIT, next op SW, data_ok three cycles later → old result discarded; SW req only after data_ok; stall held throughout.
- data_ok while stall_mem=STOP for four cycles → stays DONE, single bus transaction only, then IDLE.

Source files
------------

// File: rtl/mem_dreq_pkg.sv
// Shared definitions for the memory-stage data-access initiator: aluop codes,
// exception/stall encodings, bus size codes, load types and FSM states.
package mem_dreq_pkg;

   localparam int ALUOP_W    = 8;  // ALUOP_BUS width
   localparam int EXC_CODE_W = 5;  // EXC_CODE_BUS width

   // Memory-stage aluop codes; every other value is a non-memory op.
   localparam logic [ALUOP_W-1:0] ALUOP_NOP = 8'h00;
   localparam logic [ALUOP_W-1:0] ALUOP_LB  = 8'h90;
   localparam logic [ALUOP_W-1:0] ALUOP_LBU = 8'h91;
   localparam logic [ALUOP_W-1:0] ALUOP_LH  = 8'h92;
   localparam logic [ALUOP_W-1:0] ALUOP_LHU = 8'h93;
   localparam logic [ALUOP_W-1:0] ALUOP_LW  = 8'h94;
   localparam logic [ALUOP_W-1:0] ALUOP_SB  = 8'h98;
   localparam logic [ALUOP_W-1:0] ALUOP_SH  = 8'h99;
   localparam logic [ALUOP_W-1:0] ALUOP_SW  = 8'h9A;

   // Upstream exception code meaning "no exception".
   localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'h10;

   // stall[4] encoding.
   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   // data_size encodings on the SRAM-like bus.
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      LD_LB,
      LD_LBU,
      LD_LH,
      LD_LHU,
      LD_LW
   } ld_type_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } dreq_state_e;

   // Decoded view of the memory-stage aluop.
   typedef struct packed {
      logic       is_mem;
      logic       is_load;
      logic [1:0] size;
      ld_type_e   ld_type;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [ALUOP_W-1:0] op);
      mem_op_t d;
      d = '{is_mem: 1'b0, is_load: 1'b0, size: SZ_WORD, ld_type: LD_LW};
      case (op)
         ALUOP_LB:  d = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_BYTE, ld_type: LD_LB};
         ALUOP_LBU: d = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_BYTE, ld_type: LD_LBU};
         ALUOP_LH:  d = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_HALF, ld_type: LD_LH};
         ALUOP_LHU: d = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_HALF, ld_type: LD_LHU};
         ALUOP_LW:  d = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_WORD, ld_type: LD_LW};
         ALUOP_SB:  d = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_BYTE, ld_type: LD_LW};
         ALUOP_SH:  d = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_HALF, ld_type: LD_LW};
         ALUOP_SW:  d = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_WORD, ld_type: LD_LW};
         default:   ;
      endcase
      return d;
   endfunction

   // Replicate store data across the byte lanes so the slave can pick any lane.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] din);
      logic [31:0] w;
      case (size)
         SZ_BYTE: w = {4{din[7:0]}};
         SZ_HALF: w = {2{din[15:0]}};
         default: w = din;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_dreq_ld_ext.sv
// Load extension: selects the addressed byte/half of the returned bus word and
// sign- or zero-extends it according to the load type.
module mem_ld_ext
   import mem_dreq_pkg::*;
(
   input  ld_type_e    ld_type,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection by address offset, then extension by load type.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
      byte_sel = rdata[7:0];
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      ld_data  = rdata;
      case (offset)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      case (ld_type)
         LD_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  ld_data = {24'h0, byte_sel};
         LD_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  ld_data = {16'h0, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_dreq.sv
// Memory-stage data-access initiator. Issues one SRAM-like bus transaction per
// memory instruction, stalls the pipeline while it is in flight, returns the
// extended load result and flags misaligned accesses. Flushes either withdraw
// a not-yet-accepted request or drain an accepted one. Store-lane and load
// extension logic assume a 32-bit data bus.
module mem_dreq
   import mem_dreq_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  cpu_clk_50M,
   input  logic                  cpu_rst_n,
   input  logic [ALUOP_W-1:0]    mem_aluop,
   input  logic [31:0]           mem_wd,
   input  logic [31:0]           mem_din,
   input  logic [EXC_CODE_W-1:0] mem_exccode,
   input  logic                  flush,
   input  logic                  stall_mem,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_W-1:0]     data_addr,
   output logic [DATA_W-1:0]     data_wdata,
   input  logic                  data_addr_ok,
   input  logic                  data_data_ok,
   input  logic [DATA_W-1:0]     data_rdata,
   output logic                  stallreq_mem,
   output logic [31:0]           mem_ld_data,
   output logic                  mem_ld_valid,
   output logic                  mem_adel,
   output logic                  mem_ades
);

   dreq_state_e state, state_nxt;
   mem_op_t     op_d;
   logic        misaligned;
   logic        op_go;
   logic        issue;
   logic        ld_capture;

   // Captured per-transaction load context for the extension unit.
   ld_type_e    ld_type_q;
   logic [1:0]  ld_off_q;
   logic        is_load_q;
   logic [31:0] ld_ext_data;

   assign op_d = decode_op(mem_aluop);

   assign misaligned = op_d.is_mem &
                       (((op_d.size == SZ_HALF) & mem_wd[0]) |
                        ((op_d.size == SZ_WORD) & (mem_wd[1:0] != 2'b00)));

   assign mem_adel = misaligned &  op_d.is_load;
   assign mem_ades = misaligned & ~op_d.is_load;

   // Reset is folded in so no stall request escapes while the core is held.
   assign op_go = cpu_rst_n & op_d.is_mem & (mem_exccode == EXC_NONE) &
                  ~misaligned & ~flush;

   assign issue      = (state == S_IDLE) & op_go;
   assign ld_capture = (state == S_WAIT) & data_data_ok & ~flush & is_load_q;

   mem_ld_ext u_ld_ext (
      .ld_type (ld_type_q),
      .offset  (ld_off_q),
      .rdata   (data_rdata),
      .ld_data (ld_ext_data)
   );

   // State register, bus request fields captured on issue, load result capture.
   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state       <= S_IDLE;
         data_wr     <= 1'b0;
         data_size   <= SZ_BYTE;
         data_addr   <= '0;
         data_wdata  <= '0;
         ld_type_q   <= LD_LW;
         ld_off_q    <= 2'b00;
         is_load_q   <= 1'b0;
         mem_ld_data <= 32'h0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            data_wr    <= ~op_d.is_load;
            data_size  <= op_d.size;
            data_addr  <= mem_wd[ADDR_W-1:0];
            data_wdata <= store_lanes(op_d.size, mem_din);
            ld_type_q  <= op_d.ld_type;
            ld_off_q   <= mem_wd[1:0];
            is_load_q  <= op_d.is_load;
         end
         if (ld_capture) begin
            mem_ld_data <= ld_ext_data;
         end
      end
   end

   // Next-state logic plus request, stall and load-valid outputs.
   always_comb begin
      state_nxt    = state;
      data_req     = 1'b0;
      stallreq_mem = 1'b0;
      mem_ld_valid = 1'b0;
      case (state)
         S_IDLE: begin
            stallreq_mem = op_go;
            if (op_go) state_nxt = S_REQ;
         end
         S_REQ: begin
            data_req     = 1'b1;
            stallreq_mem = 1'b1;
            if (data_addr_ok) state_nxt = flush ? S_DRAIN : S_WAIT;
            else if (flush)   state_nxt = S_IDLE;
         end
         S_WAIT: begin
            stallreq_mem = 1'b1;
            if (flush)             state_nxt = data_data_ok ? S_IDLE : S_DRAIN;
            else if (data_data_ok) state_nxt = S_DONE;
         end
         S_DONE: begin
            mem_ld_valid = is_load_q;
            if ((stall_mem == NOSTOP) || flush) state_nxt = S_IDLE;
         end
         S_DRAIN: begin
            // The next instruction may already sit in MEM; hold it until the
            // abandoned transaction's response has been absorbed.
            stallreq_mem = op_d.is_mem & ~flush;
            if (data_data_ok) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_dreq.sv
// Self-checking bench for mem_dreq: directed scenarios plus randomized
// transactions checked against a byte-arithmetic reference model.
module tb_mem_dreq;
   import mem_dreq_pkg::*;

   logic                  cpu_clk_50M = 1'b0;
   logic                  cpu_rst_n;
   logic [ALUOP_W-1:0]    mem_aluop;
   logic [31:0]           mem_wd;
   logic [31:0]           mem_din;
   logic [EXC_CODE_W-1:0] mem_exccode;
   logic                  flush;
   logic                  stall_mem;
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [31:0]           data_addr;
   logic [31:0]           data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [31:0]           data_rdata;
   logic                  stallreq_mem;
   logic [31:0]           mem_ld_data;
   logic                  mem_ld_valid;
   logic                  mem_adel;
   logic                  mem_ades;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_ld;   // last committed load result

   logic [ALUOP_W-1:0] mem_ops [8] = '{ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU,
                                      ALUOP_LW, ALUOP_SB, ALUOP_SH, ALUOP_SW};

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   mem_dreq #(.ADDR_W(32), .DATA_W(32)) dut (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst_n    (cpu_rst_n),
      .mem_aluop    (mem_aluop),
      .mem_wd       (mem_wd),
      .mem_din      (mem_din),
      .mem_exccode  (mem_exccode),
      .flush        (flush),
      .stall_mem    (stall_mem),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .stallreq_mem (stallreq_mem),
      .mem_ld_data  (mem_ld_data),
      .mem_ld_valid (mem_ld_valid),
      .mem_adel     (mem_adel),
      .mem_ades     (mem_ades)
   );

   // ---------------- reference model ----------------
   function automatic bit m_is_mem(input logic [ALUOP_W-1:0] op);
      return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW,
                        ALUOP_SB, ALUOP_SH, ALUOP_SW};
   endfunction

   function automatic bit m_is_load(input logic [ALUOP_W-1:0] op);
      return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW};
   endfunction

   function automatic int unsigned m_bytes(input logic [ALUOP_W-1:0] op);
      if (op inside {ALUOP_LB, ALUOP_LBU, ALUOP_SB}) return 1;
      if (op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH}) return 2;
      return 4;
   endfunction

   function automatic logic [1:0] m_size(input logic [ALUOP_W-1:0] op);
      int unsigned nb = m_bytes(op);
      return (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
   endfunction

   function automatic bit m_misaligned(input logic [ALUOP_W-1:0] op, input logic [31:0] addr);
      return m_is_mem(op) && ((addr % m_bytes(op)) != 0);
   endfunction

   function automatic logic [31:0] m_ld(input logic [ALUOP_W-1:0] op, input logic [31:0] addr,
                                        input logic [31:0] rd);
      int unsigned nb = m_bytes(op);
      logic [31:0] mask, v;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v = (rd >> (8 * (addr % 4))) & mask;
      if ((op == ALUOP_LB || op == ALUOP_LH) && v[8 * nb - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [ALUOP_W-1:0] op, input logic [31:0] din);
      int unsigned nb = m_bytes(op);
      if (nb == 1) return (din & 32'h0000_00FF) * 32'h0101_0101;
      if (nb == 2) return (din & 32'h0000_FFFF) * 32'h0001_0001;
      return din;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   task automatic set_idle();
      mem_aluop    = ALUOP_NOP;
      mem_wd       = 32'h0;
      mem_din      = 32'h0;
      mem_exccode  = EXC_NONE;
      flush        = 1'b0;
      stall_mem    = NOSTOP;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
   endtask

   // Full zero-wait transaction; starts and ends just after a rising edge.
   task automatic do_txn(input string tag, input logic [ALUOP_W-1:0] op, input logic [31:0] addr,
                         input logic [31:0] din, input logic [31:0] rd);
      mem_aluop = op; mem_wd = addr; mem_din = din; mem_exccode = EXC_NONE;
      flush = 1'b0; stall_mem = NOSTOP; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge cpu_clk_50M);
      check({tag, ":issue_req"},   data_req, 1'b0);
      check({tag, ":issue_stall"}, stallreq_mem, 1'b1);
      check({tag, ":issue_adel"},  {mem_adel, mem_ades}, 2'b00);
      cyc();
      data_addr_ok = 1'b1;
      @(negedge cpu_clk_50M);
      check({tag, ":req"},       data_req, 1'b1);
      check({tag, ":req_stall"}, stallreq_mem, 1'b1);
      check({tag, ":wr"},        data_wr, !m_is_load(op));
      check({tag, ":size"},      data_size, m_size(op));
      check({tag, ":addr"},      data_addr, addr);
      if (!m_is_load(op)) check({tag, ":wdata"}, data_wdata, m_wdata(op, din));
      cyc();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
      @(negedge cpu_clk_50M);
      check({tag, ":wait_req"},   data_req, 1'b0);
      check({tag, ":wait_stall"}, stallreq_mem, 1'b1);
      check({tag, ":wait_valid"}, mem_ld_valid, 1'b0);
      cyc();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      if (m_is_load(op)) exp_ld = m_ld(op, addr, rd);
      @(negedge cpu_clk_50M);
      check({tag, ":done_stall"}, stallreq_mem, 1'b0);
      check({tag, ":done_req"},   data_req, 1'b0);
      check({tag, ":done_valid"}, mem_ld_valid, m_is_load(op));
      check({tag, ":done_data"},  mem_ld_data, exp_ld);
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check({tag, ":after_stall"}, stallreq_mem, 1'b0);
      check({tag, ":after_valid"}, mem_ld_valid, 1'b0);
      cyc();
   endtask

   // Issue a load and bring it to the WAIT state (address accepted).
   task automatic to_wait(input logic [ALUOP_W-1:0] op, input logic [31:0] addr);
      mem_aluop = op; mem_wd = addr; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      cyc();
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ALUOP_W-1:0] op;
      logic [31:0]        addr, din, rd;
      int unsigned        nb;

      // ---- reset state ----
      set_idle();
      cpu_rst_n = 1'b0;
      exp_ld    = 32'h0;
      repeat (3) cyc();
      @(negedge cpu_clk_50M);
      check("rst_req",   data_req, 1'b0);
      check("rst_wr",    data_wr, 1'b0);
      check("rst_size",  data_size, 2'd0);
      check("rst_addr",  data_addr, 32'h0);
      check("rst_wdata", data_wdata, 32'h0);
      check("rst_lddata", mem_ld_data, 32'h0);
      check("rst_valid", mem_ld_valid, 1'b0);
      check("rst_stall", stallreq_mem, 1'b0);
      cpu_rst_n = 1'b1;
      cyc();

      // ---- directed transactions ----
      do_txn("lw", ALUOP_LW, 32'h8000_0010, 32'h0, 32'h1234_5678);
      check("lw_const", mem_ld_data, 32'h1234_5678);
      do_txn("lb3", ALUOP_LB, 32'h8000_0023, 32'h0, 32'h80FF_FFFF);
      check("lb3_const", mem_ld_data, 32'hFFFF_FF80);
      do_txn("lbu3", ALUOP_LBU, 32'h8000_0023, 32'h0, 32'h80FF_FFFF);
      check("lbu3_const", mem_ld_data, 32'h0000_0080);
      do_txn("sh2", ALUOP_SH, 32'h8000_0042, 32'h0000_ABCD, 32'h0);
      check("sh2_wdata", data_wdata, 32'hABCD_ABCD);
      check("sh2_size",  data_size, 2'd1);
      check("sh2_wr",    data_wr, 1'b1);

      // ---- misaligned LW: exception, no request, no stall ----
      mem_aluop = ALUOP_LW; mem_wd = 32'h8000_0102;
      @(negedge cpu_clk_50M);
      check("mis_lw_adel",  mem_adel, 1'b1);
      check("mis_lw_ades",  mem_ades, 1'b0);
      check("mis_lw_stall", stallreq_mem, 1'b0);
      cyc();
      @(negedge cpu_clk_50M);
      check("mis_lw_req", data_req, 1'b0);
      cyc();
      set_idle();

      // ---- upstream exception suppresses issue ----
      mem_aluop = ALUOP_SW; mem_wd = 32'h8000_0200; mem_exccode = 5'h04;
      @(negedge cpu_clk_50M);
      check("exc_stall", stallreq_mem, 1'b0);
      cyc();
      @(negedge cpu_clk_50M);
      check("exc_req", data_req, 1'b0);
      cyc();
      set_idle();

      // ---- flush in REQ without addr_ok: request withdrawn ----
      mem_aluop = ALUOP_LW; mem_wd = 32'h8000_0300;
      cyc();
      flush = 1'b1;
      @(negedge cpu_clk_50M);
      check("fl_req_req", data_req, 1'b1);
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check("fl_req_gone",  data_req, 1'b0);
      check("fl_req_stall", stallreq_mem, 1'b0);
      cyc();

      // ---- flush together with addr_ok in REQ: drain ----
      mem_aluop = ALUOP_LW; mem_wd = 32'h8000_0304;
      cyc();
      flush = 1'b1; data_addr_ok = 1'b1;
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check("fl_acc_req",   data_req, 1'b0);
      check("fl_acc_stall", stallreq_mem, 1'b0);
      cyc();
      data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check("fl_acc_valid", mem_ld_valid, 1'b0);
      check("fl_acc_data",  mem_ld_data, exp_ld);
      cyc();

      // ---- flush in WAIT, next op SW waits for the drained data_ok ----
      to_wait(ALUOP_LW, 32'h8000_0400);
      flush = 1'b1;
      @(negedge cpu_clk_50M);
      check("fl_wait_stall", stallreq_mem, 1'b1);
      cyc();
      flush = 1'b0; mem_aluop = ALUOP_SW; mem_wd = 32'h8000_0500; mem_din = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         data_data_ok = (i == 2); data_rdata = 32'h5555_AAAA;
         @(negedge cpu_clk_50M);
         check($sformatf("drain%0d_stall", i), stallreq_mem, 1'b1);
         check($sformatf("drain%0d_req", i),   data_req, 1'b0);
         cyc();
      end
      do_txn("sw_after_drain", ALUOP_SW, 32'h8000_0500, 32'hCAFE_F00D, 32'h0);

      // ---- flush together with data_ok in WAIT: result discarded ----
      to_wait(ALUOP_LW, 32'h8000_0600);
      flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD;
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check("fl_dok_stall", stallreq_mem, 1'b0);
      check("fl_dok_valid", mem_ld_valid, 1'b0);
      check("fl_dok_data",  mem_ld_data, exp_ld);
      cyc();

      // ---- DONE held by STOP for four cycles, stray data_ok ignored ----
      to_wait(ALUOP_LHU, 32'h8000_0702);
      data_data_ok = 1'b1; data_rdata = 32'h9876_1234;
      exp_ld = m_ld(ALUOP_LHU, 32'h8000_0702, 32'h9876_1234);
      cyc();
      data_data_ok = 1'b0; stall_mem = STOP;
      for (int i = 0; i < 4; i++) begin
         data_data_ok = (i == 1); data_rdata = 32'h1111_2222;
         @(negedge cpu_clk_50M);
         check($sformatf("hold%0d_valid", i), mem_ld_valid, 1'b1);
         check($sformatf("hold%0d_req", i),   data_req, 1'b0);
         check($sformatf("hold%0d_stall", i), stallreq_mem, 1'b0);
         check($sformatf("hold%0d_data", i),  mem_ld_data, exp_ld);
         cyc();
      end
      data_data_ok = 1'b0; stall_mem = NOSTOP;
      @(negedge cpu_clk_50M);
      check("hold_release_valid", mem_ld_valid, 1'b1);
      cyc();
      set_idle();
      @(negedge cpu_clk_50M);
      check("hold_idle_valid", mem_ld_valid, 1'b0);
      check("hold_idle_req",   data_req, 1'b0);
      check("hold_const",      mem_ld_data, 32'h0000_9876);
      cyc();

      // ---- reset in the middle of a transaction ----
      mem_aluop = ALUOP_SB; mem_wd = 32'h8000_0801; mem_din = 32'h0000_0077;
      cyc();
      cpu_rst_n = 1'b0;
      @(negedge cpu_clk_50M);
      check("mid_rst_req_before", data_req, 1'b1);
      cyc();
      set_idle();
      exp_ld = 32'h0;
      @(negedge cpu_clk_50M);
      check("mid_rst_req",   data_req, 1'b0);
      check("mid_rst_addr",  data_addr, 32'h0);
      check("mid_rst_wr",    data_wr, 1'b0);
      check("mid_rst_stall", stallreq_mem, 1'b0);
      check("mid_rst_data",  mem_ld_data, 32'h0);
      cpu_rst_n = 1'b1;
      cyc();

      // ---- randomized aligned transactions ----
      for (int n = 0; n < 40; n++) begin
         op   = mem_ops[$urandom_range(0, 7)];
         nb   = m_bytes(op);
         addr = $urandom;
         addr = addr - (addr % nb);
         din  = $urandom;
         rd   = $urandom;
         do_txn($sformatf("rnd%0d", n), op, addr, din, rd);
      end

      // ---- randomized misaligned accesses ----
      for (int n = 0; n < 12; n++) begin
         op   = mem_ops[$urandom_range(2, 7)];
         if (op == ALUOP_SB) op = ALUOP_SW;
         nb   = m_bytes(op);
         addr = $urandom;
         addr = addr - (addr % nb) + $urandom_range(1, nb - 1);
         mem_aluop = op; mem_wd = addr;
         @(negedge cpu_clk_50M);
         check($sformatf("rmis%0d_adel", n),  mem_adel, m_is_load(op) && m_misaligned(op, addr));
         check($sformatf("rmis%0d_ades", n),  mem_ades, !m_is_load(op) && m_misaligned(op, addr));
         check($sformatf("rmis%0d_stall", n), stallreq_mem, 1'b0);
         cyc();
         @(negedge cpu_clk_50M);
         check($sformatf("rmis%0d_req", n), data_req, 1'b0);
         cyc();
         set_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
